// File: rtl/rkv_io_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus, with a released turnaround window between owners.
// Grant appears one edge after req is sampled; handoff takes TA_CYC released cycles; ownership is capped at MAX_HOLD cycles.
// Requesters simply wait with req held high. Optional contention checker: RKV_IOARB_CONTENTION_CHK_EN.
module rkv_io_bus_arbiter #(
    parameter  int NREQ     = 4,
    parameter  int DW       = 1,
    parameter  int TA_CYC   = 2,
    parameter  int MAX_HOLD = 8,
    localparam int OW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   dout,
    output logic [NREQ-1:0]      gnt,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic [DW-1:0]        din,
    output logic                 bus_err,
    inout  wire  [DW-1:0]        io
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t        state;
    logic [OW-1:0] last;
    logic [7:0]    hold_cnt;
    logic [3:0]    ta_cnt;
    logic [OW-1:0] pick;
    logic [DW-1:0] own_dat;

    // Search starts at last+1; iterating downward lets the nearest candidate win.
    always_comb begin
        pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ])
                pick = OW'((int'(last) + k) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            last     <= OW'(NREQ - 1);
            hold_cnt <= '0;
            ta_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWN;
                        owner    <= pick;
                        gnt      <= NREQ'(1) << pick;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                OWN: begin
                    if (!req[owner] || hold_cnt == 8'(MAX_HOLD)) begin
                        state    <= TURN;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        last     <= owner;
                        hold_cnt <= '0;
                        ta_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    if (ta_cnt == 4'(TA_CYC - 1)) begin
                        if (|req) begin
                            state    <= OWN;
                            owner    <= pick;
                            gnt      <= NREQ'(1) << pick;
                            busy     <= 1'b1;
                            hold_cnt <= 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        ta_cnt <= ta_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy is the drive enable, so reset releases the bus without waiting for an edge.
    assign own_dat = dout[owner*DW +: DW];
    assign io      = busy ? own_dat : {DW{1'bz}};
    assign din     = io;

`ifdef RKV_IOARB_CONTENTION_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if ((state == OWN && io !== own_dat) ||
                     (state == TURN && ta_cnt == 4'(TA_CYC - 1) && io !== {DW{1'bz}})) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_rkv_io_bus_arbiter.sv
// Directed bench for rkv_io_bus_arbiter at NREQ=4, DW=1, TA_CYC=2, MAX_HOLD=8.
module tb_rkv_io_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] dout;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [0:0] din;
    logic       bus_err;
    wire  [0:0] io;
    logic       ext_en;
    logic       ext_val;

    int n_checks = 0;
    int n_err    = 0;

`ifdef RKV_IOARB_CONTENTION_CHK_EN
    localparam logic EXP_CONT = 1'b1;
`else
    localparam logic EXP_CONT = 1'b0;
`endif

    // Grant order when all four requesters stay high from reset.
    localparam logic [3:0] ORDER_GNT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    assign io = ext_en ? ext_val : 1'bz;

    always #5 clk = ~clk;

    rkv_io_bus_arbiter #(.NREQ(4), .DW(1), .TA_CYC(2), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dout    (dout),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .din     (din),
        .bus_err (bus_err),
        .io      (io)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every dout bit is 1, so a released bus must never read back as 1.
    task automatic check_released(input string tag);
        n_checks++;
        assert (io !== 1'b1) else begin
            n_err++;
            $error("FAIL %s: io observed %b expected released", tag, io);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; dout = 4'b1111; ext_en = 1'b0; ext_val = 1'b0;
        #1;
        check("rst_gnt", 8'(gnt), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_owner", 8'(owner), 8'h0);
        check("rst_bus_err", 8'(bus_err), 8'h0);
        check_released("rst_io");
        #1 rst = 1'b0;

        // Single requester, then release with turnaround.
        req = 4'b0010;
        step();
        check("single_gnt", 8'(gnt), 8'h02);
        check("single_owner", 8'(owner), 8'h1);
        check("single_busy", 8'(busy), 8'h1);
        check("single_io", 8'(io), 8'h1);
        check("single_din", 8'(din), 8'h1);
        step();
        step();
        check("single_hold", 8'(gnt), 8'h02);
        req = 4'b0000;
        step();
        check("single_rel_gnt", 8'(gnt), 8'h0);
        check("single_rel_busy", 8'(busy), 8'h0);
        check_released("single_rel_io");
        step();
        check_released("single_turn2_io");
        step();
        check("single_idle_gnt", 8'(gnt), 8'h0);

        // Request arriving mid-turnaround waits for the window to close.
        req = 4'b0001;
        step();
        check("rdt_gnt0", 8'(gnt), 8'h01);
        req = 4'b0000;
        step();
        check("rdt_turn1", 8'(gnt), 8'h0);
        req = 4'b1000;
        step();
        check("rdt_turn2", 8'(gnt), 8'h0);
        check_released("rdt_turn2_io");
        step();
        check("rdt_gnt3", 8'(gnt), 8'h08);
        check("rdt_owner3", 8'(owner), 8'h3);
        req = 4'b0000;
        step(); step(); step();

        // Forced release: lone requester is re-granted after each turnaround.
        req = 4'b0100;
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                check($sformatf("force_own_g%0d_c%0d", g, c), 8'(gnt), 8'h04);
            end
            check("force_owner", 8'(owner), 8'h2);
            step();
            check("force_turn1", 8'(gnt), 8'h0);
            check_released("force_turn1_io");
            step();
            check("force_turn2", 8'(busy), 8'h0);
        end
        step();
        check("force_regrant", 8'(gnt), 8'h04);
        req = 4'b0000;
        step(); step(); step();

        // All requesters from reset: 0,1,2,3,0 with 8-cycle holds.
        rst = 1'b1;
        #1 rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                check($sformatf("rr_k%0d_c%0d", k, c), 8'(gnt), 8'(ORDER_GNT[k]));
            end
            if (k < 4) begin
                for (int c = 0; c < 2; c++) begin
                    step();
                    check($sformatf("rr_turn_k%0d_c%0d", k, c), 8'(gnt), 8'h0);
                end
            end
        end
        req = 4'b0000;
        step(); step(); step();

        // Reset mid-ownership releases the bus asynchronously.
        req = 4'b0010;
        step();
        check("mrst_gnt", 8'(gnt), 8'h02);
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("mrst_gnt_drop", 8'(gnt), 8'h0);
        check("mrst_busy_drop", 8'(busy), 8'h0);
        check_released("mrst_io");
        req = 4'b1001;
        #1 rst = 1'b0;
        step();
        check("mrst_first_gnt", 8'(gnt), 8'h01);
        check("mrst_first_owner", 8'(owner), 8'h0);
        check("cont_pre_io", 8'(io), 8'h1);

        // Foreign driver fights the owner.
        ext_en = 1'b1; ext_val = 1'b0;
        step();
        check("cont_err", 8'(bus_err), 8'(EXP_CONT));
        ext_en = 1'b0;
        req = 4'b0000;
        step(); step(); step();
        check("cont_sticky", 8'(bus_err), 8'(EXP_CONT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
